multicycle_controller: RTL
==========================

// Module: multicycle_controller
// PURPOSE
//  Multicycle FSM that sequences the register-file/ALU datapath for an RV32I subset.
//  Fetches 32-bit instructions over a req/ack port, decodes them and drives the datapath
//  controls (RS1/RS2/RD/IMM/ALUControl/ALUSrc/MemtoReg/RegWrite/link/pclink). Drives
//  data-memory read/write strobes and owns the program counter.
//  Supports ADD, AND, ADDI, ANDI, LW, SW, BEQ, JAL, JALR; any other encoding halts.
// PARAMETERS
//  NBITS       8   datapath/PC width
//  NREGS       32  register count; register index width = $clog2(NREGS)
//  WIDTH_ALUF  4   ALUControl width
// PORTS
//  clock       in   1           single clock, rising edge
//  reset       in   1           synchronous, active-high
//  Instr       in   32          instruction word, sampled when ifetch_ack=1
//  ifetch_req  out  1           instruction fetch request at address PC
//  ifetch_ack  in   1           fetch complete, Instr valid this cycle
//  PC          out  NBITS       current program counter
//  RS1,RS2,RD  out  $clog2(NREGS)  register selects (Instr[19:15],[24:20],[11:7], truncated)
//  IMM         out  NBITS       sign-extended immediate, low NBITS bits
//  ALUControl  out  WIDTH_ALUF  ADD=4'b0000, SUB=4'b1000, AND=4'b0111
//  ALUSrc      out  1           1 = SrcB from IMM
//  MemtoReg    out  1           1 = write-back from ReadData
//  RegWrite    out  1           register-file write strobe (single-cycle pulse)
//  link        out  1           write pclink into RD
//  pclink      out  NBITS       PC+4 of current instruction
//  Zero        in   1           ALU zero flag from datapath
//  PCReg       in   NBITS       RS1 value from datapath (JALR target base)
//  MemRead     out  1           data-memory read strobe, held until mem_ack
//  MemWrite    out  1           data-memory write strobe, held until mem_ack
//  mem_ack     in   1           data-memory access complete
//  halted      out  1           illegal instruction seen; sticky until reset
// BEHAVIOUR
//  Reset: state=FETCH, PC=0, IR=0; all strobes (ifetch_req excepted), link, halted = 0.
//  States: FETCH -> DECODE -> EXEC -> {FETCH | MEM -> (WB | FETCH)}; HALT absorbing.
//  FETCH: ifetch_req=1 until ifetch_ack; on ack IR<=Instr, go DECODE. Ack in first cycle ok.
//  DECODE (1 cycle): fields/IMM driven from IR; opcode checked; illegal (incl. funct3/7
//   mismatch) -> HALT, halted=1, PC frozen, no strobes.
//  EXEC: OP/OP-IMM: ALUSrc=1 for I-type, ALUControl per funct3 (000 ADD, 111 AND);
//   RegWrite=1 one cycle; PC<=PC+4; -> FETCH.
//   LW/SW: ALUSrc=1, ADD -> MEM. BEQ: ALUSrc=0, SUB; PC<=Zero ? PC+IMM : PC+4; -> FETCH.
//   JAL: link=1, RegWrite=1, pclink=PC+4, PC<=PC+IMM. JALR: same link, PC<=(PCReg+IMM)&~1.
//  MEM: LW MemRead=1 / SW MemWrite=1 held until mem_ack. SW on ack: PC+=4 -> FETCH.
//   LW on ack -> WB. WB: MemtoReg=1, RegWrite=1 one cycle, PC+=4 -> FETCH.
//  Latency (zero-wait acks): ALU/branch/jump 3 cycles, SW 4, LW 5.
//  RD=0 writes still pulse RegWrite; datapath ignores them.
//  All PC arithmetic mod 2^NBITS (wraps silently); IMM sign-extended then truncated.
//  Control outputs are registered-state decodes, stable for the whole state; default 0.
//  reset overrides any state, incl. pending fetch or memory wait; in-flight ack ignored.
// TESTING
//  Reset held 2 cycles -> PC=0, state FETCH, ifetch_req=1, RegWrite=MemRead=MemWrite=0.
//  ADDI x1,x0,5 (0x00500093), ack immediate -> EXEC: RD=1,IMM=5,ALUSrc=1,RegWrite 1-cyc; PC=4.
//  LW x2,4(x1), mem_ack after 3 cycles -> MemRead high 3 cycles, WB MemtoReg=1,RegWrite; PC+4.
//  BEQ +8 with Zero=1 -> PC+=8; repeat with Zero=0 -> PC+=4; RegWrite never asserted.
//  JAL x1,+16 at PC=8 -> link=1, pclink=12, RegWrite pulse, PC=24; PC near 2^NBITS wraps.
//  Opcode 0x7F -> halted=1 after DECODE, no further fetch; reset during MEM wait -> PC=0, FETCH.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle FSM sequencing an RV32I-subset register-file/ALU datapath
module multicycle_controller #(
  parameter int NBITS      = 8,
  parameter int NREGS      = 32,
  parameter int WIDTH_ALUF = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [31:0]              Instr,
  output logic                     ifetch_req,
  input  logic                     ifetch_ack,
  output logic [NBITS-1:0]         PC,
  output logic [$clog2(NREGS)-1:0] RS1,
  output logic [$clog2(NREGS)-1:0] RS2,
  output logic [$clog2(NREGS)-1:0] RD,
  output logic [NBITS-1:0]         IMM,
  output logic [WIDTH_ALUF-1:0]    ALUControl,
  output logic                     ALUSrc,
  output logic                     MemtoReg,
  output logic                     RegWrite,
  output logic                     link,
  output logic [NBITS-1:0]         pclink,
  input  logic                     Zero,
  input  logic [NBITS-1:0]         PCReg,
  output logic                     MemRead,
  output logic                     MemWrite,
  input  logic                     mem_ack,
  output logic                     halted
);
  localparam int RW = $clog2(NREGS);
  localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd5;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011, OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
  localparam logic [WIDTH_ALUF-1:0] ALU_ADD = WIDTH_ALUF'(4'b0000);
  localparam logic [WIDTH_ALUF-1:0] ALU_SUB = WIDTH_ALUF'(4'b1000);
  localparam logic [WIDTH_ALUF-1:0] ALU_AND = WIDTH_ALUF'(4'b0111);
  logic [2:0] state_q, state_d;
  logic [NBITS-1:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic halted_q, halted_d;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic is_op, is_opi, is_lw, is_sw, is_beq, is_jal, is_jalr, legal, is_mem;
  logic in_exec, in_mem, in_wb;
  logic [31:0] imm32;
  logic [NBITS-1:0] pc4, br_t, jalr_t;
  assign opc = ir_q[6:0];
  assign f3 = ir_q[14:12];
  assign f7 = ir_q[31:25];
  assign is_op = opc == OP_R;
  assign is_opi = opc == OP_I;
  assign is_lw = opc == OP_LW;
  assign is_sw = opc == OP_SW;
  assign is_beq = opc == OP_BEQ;
  assign is_jal = opc == OP_JAL;
  assign is_jalr = opc == OP_JALR;
  assign is_mem = is_lw || is_sw;
  assign legal = (is_op && f7 == 7'd0 && (f3 == 3'b000 || f3 == 3'b111)) ||
                 (is_opi && (f3 == 3'b000 || f3 == 3'b111)) ||
                 (is_mem && f3 == 3'b010) || ((is_beq || is_jalr) && f3 == 3'b000) || is_jal;
  assign imm32 = is_sw  ? {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]} :
                 is_beq ? {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0} :
                 is_jal ? {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0} :
                          {{20{ir_q[31]}}, ir_q[31:20]};
  assign IMM = NBITS'(imm32);
  assign RS1 = RW'(ir_q[19:15]);
  assign RS2 = RW'(ir_q[24:20]);
  assign RD = RW'(ir_q[11:7]);
  assign pc4 = pc_q + NBITS'(4);
  assign br_t = pc_q + IMM;
  assign jalr_t = (PCReg + IMM) & ~NBITS'(1);
  assign in_exec = state_q == EXEC;
  assign in_mem = state_q == MEM;
  assign in_wb = state_q == WB;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    halted_d = halted_q;
    case (state_q)
      FETCH: if (ifetch_ack) begin
        ir_d = Instr;
        state_d = DECODE;
      end
      DECODE: begin
        state_d = legal ? EXEC : HALT;
        halted_d = !legal;
      end
      EXEC: begin
        state_d = is_mem ? MEM : FETCH;
        pc_d = is_jal ? br_t : is_jalr ? jalr_t : (is_beq && Zero) ? br_t : is_mem ? pc_q : pc4;
      end
      MEM: if (mem_ack) begin
        state_d = is_lw ? WB : FETCH;
        pc_d = is_lw ? pc_q : pc4;
      end
      WB: begin
        state_d = FETCH;
        pc_d = pc4;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q <= '0;
      ir_q <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      halted_q <= halted_d;
    end
  end
  assign PC = pc_q;
  assign pclink = pc4;
  assign halted = halted_q;
  assign ifetch_req = state_q == FETCH;
  // ALUSrc stays up through MEM so the address remains stable for the memory access
  assign ALUSrc = (in_exec && (is_opi || is_mem)) || in_mem;
  assign ALUControl = (in_exec && is_beq) ? ALU_SUB :
                      (in_exec && (is_op || is_opi) && f3 == 3'b111) ? ALU_AND : ALU_ADD;
  assign RegWrite = (in_exec && (is_op || is_opi || is_jal || is_jalr)) || in_wb;
  assign link = in_exec && (is_jal || is_jalr);
  assign MemRead = in_mem && is_lw;
  assign MemWrite = in_mem && is_sw;
  assign MemtoReg = in_wb;
endmodule
